// File: rtl/regfile_sequencer_4.sv
// regfile_sequencer_4
// Four-state micro-sequencer that runs one register-transfer instruction at a
// time against an external 4-entry x 4-bit register file. It fetches both
// operands, computes the result in a small ALU and writes the result back.
//
// State table:
//   IDLE | ready for a new instruction; instruction register loads on handshake
//   READ | drive read addresses from latched rs0/rs1, capture operands A/B
//   EXEC | compute result and flags into registers (NOP retires here)
//   WB   | single-cycle write strobe of the result to latched rd, done pulse
//
// Ports:
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_valid / o_ready               instruction handshake
//   i_opcode, i_rd, i_rs0, i_rs1,
//   i_imm                           instruction fields
//   o_reg_read_0/1, i_port_read_0/1 register file read ports (combinational)
//   o_reg_write, o_port_write,
//   o_write_enable                  register file write port
//   o_done                          one-cycle retire pulse
//   o_zero, o_carry                 sticky result flags
module regfile_sequencer_4 #(
  parameter int DATA_W = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_opcode,
  input  logic [1:0]        i_rd,
  input  logic [1:0]        i_rs0,
  input  logic [1:0]        i_rs1,
  input  logic [DATA_W-1:0] i_imm,
  output logic [1:0]        o_reg_read_0,
  output logic [1:0]        o_reg_read_1,
  input  logic [DATA_W-1:0] i_port_read_0,
  input  logic [DATA_W-1:0] i_port_read_1,
  output logic [1:0]        o_reg_write,
  output logic [DATA_W-1:0] o_port_write,
  output logic              o_write_enable,
  output logic              o_done,
  output logic              o_zero,
  output logic              o_carry
);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDI = 3'd1;
  localparam logic [2:0] OP_MOV = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_op;
  logic [1:0]        r_rd;
  logic [1:0]        r_rs0;
  logic [1:0]        r_rs1;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_carry;

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_alu;
  logic              w_carry_new;
  logic              w_carry_upd;

  // Extra top bit of the difference is the borrow (set iff A < B).
  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  always_comb begin
    w_alu       = '0;
    w_carry_new = r_carry;
    w_carry_upd = 1'b0;
    case (r_op)
      OP_LDI: w_alu = r_imm;
      OP_MOV: w_alu = r_a;
      OP_ADD: begin
        w_alu       = w_sum[DATA_W-1:0];
        w_carry_new = w_sum[DATA_W];
        w_carry_upd = 1'b1;
      end
      OP_SUB: begin
        w_alu       = w_diff[DATA_W-1:0];
        w_carry_new = w_diff[DATA_W];
        w_carry_upd = 1'b1;
      end
      OP_AND: w_alu = r_a & r_b;
      OP_OR:  w_alu = r_a | r_b;
      OP_XOR: w_alu = r_a ^ r_b;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_valid) w_next = S_READ;
      S_READ: w_next = S_EXEC;
      S_EXEC: w_next = (r_op == OP_NOP) ? S_IDLE : S_WB;
      S_WB:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_rd     <= '0;
      r_rs0    <= '0;
      r_rs1    <= '0;
      r_imm    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (i_valid) begin
          r_op  <= i_opcode;
          r_rd  <= i_rd;
          r_rs0 <= i_rs0;
          r_rs1 <= i_rs1;
          r_imm <= i_imm;
        end
        S_READ: begin
          r_a <= i_port_read_0;
          r_b <= i_port_read_1;
        end
        S_EXEC: if (r_op != OP_NOP) begin
          r_result <= w_alu;
          r_zero   <= (w_alu == '0);
          if (w_carry_upd) r_carry <= w_carry_new;
        end
        default: ;
      endcase
    end
  end

  assign o_ready      = (r_state == S_IDLE);
  assign o_reg_read_0 = (r_state == S_READ) ? r_rs0 : 2'd0;
  assign o_reg_read_1 = (r_state == S_READ) ? r_rs1 : 2'd0;
  assign o_reg_write  = r_rd;
  assign o_port_write = (r_state == S_WB) ? r_result : '0;
  // Reset in the WB cycle must suppress the write even though the state
  // register still reads WB during that cycle.
  assign o_write_enable = (r_state == S_WB) & ~i_reset;
  assign o_done = ((r_state == S_WB) |
                   ((r_state == S_EXEC) & (r_op == OP_NOP))) & ~i_reset;
  assign o_zero  = r_zero;
  assign o_carry = r_carry;

endmodule

// File: tb/tb_regfile_sequencer_4.sv
module tb_regfile_sequencer_4;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_valid;
  logic       o_ready;
  logic [2:0] i_opcode;
  logic [1:0] i_rd, i_rs0, i_rs1;
  logic [3:0] i_imm;
  logic [1:0] o_reg_read_0, o_reg_read_1, o_reg_write;
  logic [3:0] i_port_read_0, i_port_read_1, o_port_write;
  logic       o_write_enable, o_done, o_zero, o_carry;

  int checks = 0;
  int errors = 0;

  // Register file the sequencer drives.
  logic [3:0] rf [4] = '{default: 4'd0};
  // Reference model state.
  logic [3:0] m_rf [4] = '{default: 4'd0};
  logic       m_zero  = 1'b0;
  logic       m_carry = 1'b0;

  always #5 i_clk = ~i_clk;

  assign i_port_read_0 = rf[o_reg_read_0];
  assign i_port_read_1 = rf[o_reg_read_1];

  always @(posedge i_clk)
    if (o_write_enable) rf[o_reg_write] <= o_port_write;

  regfile_sequencer_4 #(.DATA_W(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_opcode(i_opcode), .i_rd(i_rd), .i_rs0(i_rs0), .i_rs1(i_rs1),
    .i_imm(i_imm), .o_reg_read_0(o_reg_read_0), .o_reg_read_1(o_reg_read_1),
    .i_port_read_0(i_port_read_0), .i_port_read_1(i_port_read_1),
    .o_reg_write(o_reg_write), .o_port_write(o_port_write),
    .o_write_enable(o_write_enable), .o_done(o_done),
    .o_zero(o_zero), .o_carry(o_carry)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rf();
    for (int i = 0; i < 4; i++) chk("rf_content", rf[i], m_rf[i]);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (o_ready !== 1'b1 && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    chk("ready_wait", o_ready, 1);
  endtask

  // Reference semantics: result and flag effects from the instruction rules.
  task automatic model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] imm, output logic [3:0] res, output logic c_new,
                       output logic c_upd);
    int s;
    res = 4'd0; c_new = m_carry; c_upd = 1'b0;
    case (op)
      3'd1: res = imm;
      3'd2: res = a;
      3'd3: begin s = int'(a) + int'(b); res = s[3:0]; c_new = (s > 15); c_upd = 1'b1; end
      3'd4: begin s = int'(a) - int'(b); res = s[3:0]; c_new = (a < b); c_upd = 1'b1; end
      3'd5: res = a & b;
      3'd6: res = a | b;
      3'd7: res = a ^ b;
      default: res = 4'd0;
    endcase
  endtask

  // Issues one instruction at the first ready cycle and checks it cycle by
  // cycle until the sequencer is ready again. i_valid drops and may be
  // re-raised by the next call in the same time step.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs0,
                       input logic [1:0] rs1, input logic [3:0] imm);
    logic [3:0] res;
    logic c_new, c_upd;
    wait_ready();
    model(op, m_rf[rs0], m_rf[rs1], imm, res, c_new, c_upd);
    i_opcode = op; i_rd = rd; i_rs0 = rs0; i_rs1 = rs1; i_imm = imm; i_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);  // cycle 1: READ
    i_valid = 1'b0;
    chk("read_ready", o_ready, 0);
    chk("read_addr0", o_reg_read_0, rs0);
    chk("read_addr1", o_reg_read_1, rs1);
    chk("read_we", o_write_enable, 0);
    chk("read_done", o_done, 0);
    @(negedge i_clk);  // cycle 2: EXEC
    chk("exec_done", o_done, (op == 3'd0));
    chk("exec_we", o_write_enable, 0);
    chk("exec_ready", o_ready, 0);
    if (op != 3'd0) begin
      @(negedge i_clk);  // cycle 3: WB
      m_rf[rd] = res;
      m_zero = (res == 4'd0);
      if (c_upd) m_carry = c_new;
      chk("wb_we", o_write_enable, 1);
      chk("wb_addr", o_reg_write, rd);
      chk("wb_data", o_port_write, res);
      chk("wb_done", o_done, 1);
      chk("wb_ready", o_ready, 0);
    end
    @(negedge i_clk);  // ready again
    chk("end_ready", o_ready, 1);
    chk("end_done", o_done, 0);
    chk("end_we", o_write_enable, 0);
    chk("end_pwrite", o_port_write, 0);
    chk("end_raddr", o_reg_read_0, 0);
    chk("zero", o_zero, m_zero);
    chk("carry", o_carry, m_carry);
    chk_rf();
  endtask

  // Starts an ADD and asserts reset in the given cycle (2 = EXEC, 3 = WB).
  task automatic reset_during(input int cyc, input logic [1:0] rd);
    wait_ready();
    i_opcode = 3'd3; i_rd = rd; i_rs0 = 2'd0; i_rs1 = 2'd1; i_imm = 4'd0; i_valid = 1'b1;
    @(posedge i_clk);
    for (int k = 1; k <= cyc; k++) begin
      @(negedge i_clk);
      i_valid = 1'b0;
    end
    i_reset = 1'b1;
    #1;
    chk("rst_cycle_we", o_write_enable, 0);
    chk("rst_cycle_done", o_done, 0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    m_zero = 1'b0; m_carry = 1'b0;
    chk("rst_ready", o_ready, 1);
    chk("rst_we", o_write_enable, 0);
    chk("rst_done", o_done, 0);
    chk("rst_zero", o_zero, 0);
    chk("rst_carry", o_carry, 0);
    @(negedge i_clk);
    chk("rst_quiet_we", o_write_enable, 0);
    chk_rf();
  endtask

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_opcode = 3'd0;
    i_rd = 2'd0; i_rs0 = 2'd0; i_rs1 = 2'd0; i_imm = 4'd0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    chk("reset_ready", o_ready, 1);
    chk("reset_we", o_write_enable, 0);
    chk("reset_done", o_done, 0);
    chk("reset_zero", o_zero, 0);
    chk("reset_carry", o_carry, 0);

    // Directed: LDI, ADD with carry, SUB to zero.
    issue(3'd1, 2'd2, 2'd0, 2'd0, 4'hA);
    issue(3'd1, 2'd0, 2'd0, 2'd0, 4'h9);
    issue(3'd1, 2'd1, 2'd0, 2'd0, 4'h8);
    issue(3'd3, 2'd3, 2'd0, 2'd1, 4'h0);
    chk("add_result", rf[3], 4'h1);
    chk("add_carry", o_carry, 1);
    issue(3'd4, 2'd2, 2'd0, 2'd0, 4'h0);
    chk("sub_zero", o_zero, 1);
    chk("sub_nocarry", o_carry, 0);

    // Borrow, then AND leaves carry alone.
    issue(3'd1, 2'd1, 2'd0, 2'd0, 4'h3);
    issue(3'd1, 2'd0, 2'd0, 2'd0, 4'h5);
    issue(3'd4, 2'd2, 2'd1, 2'd0, 4'h0);
    chk("sub_borrow_val", rf[2], 4'hE);
    issue(3'd5, 2'd3, 2'd1, 2'd0, 4'h0);
    chk("and_val", rf[3], 4'h1);
    chk("and_carry_kept", o_carry, 1);

    // Dependent chain, rd == rs, and NOP.
    issue(3'd1, 2'd1, 2'd0, 2'd0, 4'h4);
    issue(3'd2, 2'd2, 2'd1, 2'd0, 4'h0);
    chk("mov_dep", rf[2], 4'h4);
    issue(3'd3, 2'd1, 2'd1, 2'd1, 4'h0);
    issue(3'd0, 2'd3, 2'd2, 2'd1, 4'hF);

    // Reset during EXEC and during WB.
    reset_during(2, 2'd3);
    issue(3'd1, 2'd0, 2'd0, 2'd0, 4'hC);
    reset_during(3, 2'd2);

    // Randomized instruction stream against the model.
    for (int n = 0; n < 60; n++)
      issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
